// File: rtl/wr_fram_pack_pkg.sv
// Shared definitions for the video frame-buffer write packer and its read-side twin.
// Holds the request FSM encoding and the default buffer/DDR geometry.
package wr_fram_pack_pkg;

  localparam int PIX_PER_WORD        = 4;
  localparam int DEF_PIX_WIDTH       = 32;
  localparam int DEF_WORD_WIDTH      = PIX_PER_WORD * DEF_PIX_WIDTH;
  localparam int DEF_BUF_ADDR_WIDTH  = 10;
  localparam int DEF_DDR_ADDR_WIDTH  = 28;
  localparam int DEF_BURST_LEN       = 16;
  localparam int DEF_FRAME_WORDS     = 230400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fsm_st_e;

endpackage

// File: rtl/wr_fram_pack_if.sv
// Pixel input, line-buffer write port and DDR burst-request handshake of wr_fram_pack.
// The packer itself is the slave; the pixel source / engine side is the master.
interface wr_fram_pack_if import wr_fram_pack_pkg::*; #(
  parameter int PIX_WIDTH      = DEF_PIX_WIDTH,
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int BUF_ADDR_WIDTH = DEF_BUF_ADDR_WIDTH,
  parameter int DDR_ADDR_WIDTH = DEF_DDR_ADDR_WIDTH
) ();

  logic                      vs_in;
  logic                      pix_vld;
  logic [PIX_WIDTH-1:0]      pix_data;
  logic                      buf_wr_en;
  logic [BUF_ADDR_WIDTH-1:0] buf_wr_addr;
  logic [WORD_WIDTH-1:0]     buf_wr_data;
  logic                      burst_req;
  logic [BUF_ADDR_WIDTH-1:0] burst_buf_addr;
  logic [DDR_ADDR_WIDTH-1:0] burst_ddr_addr;
  logic                      burst_ack;
  logic                      burst_done;
  logic                      overflow;

  modport slave (
    input  vs_in, pix_vld, pix_data, burst_ack, burst_done,
    output buf_wr_en, buf_wr_addr, buf_wr_data,
           burst_req, burst_buf_addr, burst_ddr_addr, overflow
  );

  modport master (
    output vs_in, pix_vld, pix_data, burst_ack, burst_done,
    input  buf_wr_en, buf_wr_addr, buf_wr_data,
           burst_req, burst_buf_addr, burst_ddr_addr, overflow
  );

endinterface

// File: rtl/wr_fram_pack_packer.sv
// Lane counter and assembly register: gathers PIX_PER_WORD pixels into one word.
// word_o/word_vld_o are combinational in the cycle the last pixel arrives.
module wr_fram_pack_packer import wr_fram_pack_pkg::*; #(
  parameter int PIX_WIDTH  = DEF_PIX_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  vs_i,
  input  logic                  pix_vld_i,
  input  logic [PIX_WIDTH-1:0]  pix_data_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  word_vld_o
);

  localparam int LW = $clog2(PIX_PER_WORD);

  logic [LW-1:0]                          lane_q;
  logic [LW-1:0]                          lane;
  logic [PIX_PER_WORD-2:0][PIX_WIDTH-1:0] asm_q;

  // A frame start restarts packing; a pixel in that same cycle is lane 0.
  assign lane       = vs_i ? '0 : lane_q;
  assign word_vld_o = pix_vld_i && (lane == LW'(PIX_PER_WORD - 1));
  assign word_o     = {pix_data_i, asm_q};

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      lane_q <= '0;
      asm_q  <= '0;
    end else begin
      if (pix_vld_i) lane_q <= lane + LW'(1);
      else if (vs_i) lane_q <= '0;
      for (int g = 0; g < PIX_PER_WORD - 1; g++)
        if (pix_vld_i && (lane == LW'(g))) asm_q[g] <= pix_data_i;
    end
  end

endmodule

// File: rtl/wr_fram_pack.sv
// Write-side frame buffer packer: packs pixels into line-buffer words and hands
// completed BURST_LEN-word chunks to the DDR write engine, one burst at a time.
module wr_fram_pack import wr_fram_pack_pkg::*; #(
  parameter int PIX_WIDTH      = DEF_PIX_WIDTH,
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int BUF_ADDR_WIDTH = DEF_BUF_ADDR_WIDTH,
  parameter int BURST_LEN      = DEF_BURST_LEN,
  parameter int DDR_ADDR_WIDTH = DEF_DDR_ADDR_WIDTH,
  parameter int FRAME_WORDS    = DEF_FRAME_WORDS
) (
  input  logic           wr_clk,
  input  logic           wr_rst,
  wr_fram_pack_if.slave  bus
);

  localparam int CW = BUF_ADDR_WIDTH + 1;
  localparam logic [CW-1:0]             DEPTH    = {1'b1, {BUF_ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0]             BL_CNT   = CW'(BURST_LEN);
  localparam logic [BUF_ADDR_WIDTH-1:0] BL_ADDR  = BUF_ADDR_WIDTH'(BURST_LEN);
  localparam logic [DDR_ADDR_WIDTH-1:0] DDR_STEP = DDR_ADDR_WIDTH'(BURST_LEN);
  localparam logic [DDR_ADDR_WIDTH-1:0] DDR_LAST = DDR_ADDR_WIDTH'(FRAME_WORDS - BURST_LEN);

  logic [WORD_WIDTH-1:0]     word;
  logic                      word_vld;

  fsm_st_e                   state_q;
  logic [BUF_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, req_ptr_q;
  logic [CW-1:0]             occ_q, occ_d, pend_q, pend_d;
  logic [DDR_ADDR_WIDTH-1:0] ddr_addr_q;
  logic                      resync_q;

  logic                      buf_wr_en_q;
  logic [BUF_ADDR_WIDTH-1:0] buf_wr_addr_q;
  logic [WORD_WIDTH-1:0]     buf_wr_data_q;
  logic                      burst_req_q;
  logic [BUF_ADDR_WIDTH-1:0] burst_buf_addr_q;
  logic [DDR_ADDR_WIDTH-1:0] burst_ddr_addr_q;
  logic                      overflow_q;

  logic ack_fire, done_fire, discard, wr_ok, drop;

  wr_fram_pack_packer #(
    .PIX_WIDTH  (PIX_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_packer (
    .wr_clk     (wr_clk),
    .wr_rst     (wr_rst),
    .vs_i       (bus.vs_in),
    .pix_vld_i  (bus.pix_vld),
    .pix_data_i (bus.pix_data),
    .word_o     (word),
    .word_vld_o (word_vld)
  );

  // Slots freed by a burst_done in the same cycle are usable by the arriving word.
  // A frame restart rewinds the write pointer to the first unrequested word,
  // immediately in IDLE or once the outstanding burst has been retired.
  always_comb begin
    ack_fire  = (state_q == ST_REQ)  && bus.burst_ack;
    done_fire = (state_q == ST_WAIT) && bus.burst_done;
    discard   = ((state_q == ST_IDLE) && bus.vs_in) ||
                (done_fire && (resync_q || bus.vs_in));
    wr_ok     = word_vld && ((occ_q != DEPTH) || done_fire);
    drop      = word_vld && !wr_ok;

    wr_ptr_d = wr_ptr_q;
    if (discard)    wr_ptr_d = req_ptr_q;
    else if (wr_ok) wr_ptr_d = wr_ptr_q + BUF_ADDR_WIDTH'(1);

    occ_d = occ_q + {{(CW-1){1'b0}}, wr_ok} - (done_fire ? BL_CNT : '0);

    pend_d = pend_q + {{(CW-1){1'b0}}, wr_ok} - (ack_fire ? BL_CNT : '0);
    if (discard) pend_d = '0;
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_ptr_q      <= '0;
      occ_q         <= '0;
      pend_q        <= '0;
      buf_wr_en_q   <= 1'b0;
      buf_wr_addr_q <= '0;
      buf_wr_data_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
      buf_wr_en_q <= wr_ok;
      if (wr_ok) begin
        buf_wr_addr_q <= wr_ptr_q;
        buf_wr_data_q <= word;
      end
      if (bus.vs_in)  overflow_q <= 1'b0;
      else if (drop)  overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q          <= ST_IDLE;
      req_ptr_q        <= '0;
      ddr_addr_q       <= '0;
      resync_q         <= 1'b0;
      burst_req_q      <= 1'b0;
      burst_buf_addr_q <= '0;
      burst_ddr_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.vs_in && (pend_q >= BL_CNT)) begin
            state_q          <= ST_REQ;
            burst_req_q      <= 1'b1;
            burst_buf_addr_q <= req_ptr_q;
            burst_ddr_addr_q <= ddr_addr_q;
          end
        end
        ST_REQ: begin
          if (bus.burst_ack) begin
            state_q     <= ST_WAIT;
            burst_req_q <= 1'b0;
            req_ptr_q   <= req_ptr_q + BL_ADDR;
            // After a frame restart the next frame must begin at DDR word 0.
            if (resync_q || bus.vs_in)     ddr_addr_q <= '0;
            else if (ddr_addr_q == DDR_LAST) ddr_addr_q <= '0;
            else                           ddr_addr_q <= ddr_addr_q + DDR_STEP;
          end
        end
        ST_WAIT: begin
          if (bus.burst_done) begin
            state_q  <= ST_IDLE;
            resync_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (bus.vs_in) begin
        ddr_addr_q <= '0;
        resync_q   <= (state_q == ST_REQ) || ((state_q == ST_WAIT) && !bus.burst_done);
      end
    end
  end

  assign bus.buf_wr_en      = buf_wr_en_q;
  assign bus.buf_wr_addr    = buf_wr_addr_q;
  assign bus.buf_wr_data    = buf_wr_data_q;
  assign bus.burst_req      = burst_req_q;
  assign bus.burst_buf_addr = burst_buf_addr_q;
  assign bus.burst_ddr_addr = burst_ddr_addr_q;
  assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_wr_fram_pack.sv
// Directed bench for wr_fram_pack: packing, burst handshake, full/overflow,
// frame resync and DDR address wrap (FRAME_WORDS overridden to 32).
module tb_wr_fram_pack;

  logic wr_clk = 1'b0;
  logic wr_rst = 1'b1;
  always #5 wr_clk = ~wr_clk;

  wr_fram_pack_if bus ();

  logic eng_ack = 1'b0, eng_done = 1'b0;
  logic man_ack = 1'b0, man_done = 1'b0;
  logic auto_eng = 1'b0;
  assign bus.burst_ack  = eng_ack | man_ack;
  assign bus.burst_done = eng_done | man_done;

  wr_fram_pack #(.FRAME_WORDS(32)) dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Capture of buffer writes and burst requests, sampled on the falling edge.
  logic [9:0]   wa_q[$];
  logic [127:0] wd_q[$];
  logic [9:0]   rb_q[$];
  logic [27:0]  rd_q[$];
  logic         req_prev = 1'b0;
  int           unstable = 0;
  logic [9:0]   hold_b = '0;
  logic [27:0]  hold_d = '0;

  always @(negedge wr_clk) begin
    if (bus.buf_wr_en) begin
      wa_q.push_back(bus.buf_wr_addr);
      wd_q.push_back(bus.buf_wr_data);
    end
    if (bus.burst_req && !req_prev) begin
      rb_q.push_back(bus.burst_buf_addr);
      rd_q.push_back(bus.burst_ddr_addr);
      hold_b <= bus.burst_buf_addr;
      hold_d <= bus.burst_ddr_addr;
    end else if (bus.burst_req && ((bus.burst_buf_addr != hold_b) || (bus.burst_ddr_addr != hold_d))) begin
      unstable <= unstable + 1;
    end
    req_prev <= bus.burst_req;
  end

  // Engine model: ack 2 cycles after the request, done 20 cycles after the ack.
  always begin
    @(negedge wr_clk);
    if (auto_eng && bus.burst_req) begin
      @(negedge wr_clk);
      eng_ack = 1'b1;
      @(negedge wr_clk);
      eng_ack = 1'b0;
      repeat (19) @(negedge wr_clk);
      eng_done = 1'b1;
      @(negedge wr_clk);
      eng_done = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, observed running, expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pix(input logic [31:0] v);
    bus.pix_vld  = 1'b1;
    bus.pix_data = v;
    tick();
    bus.pix_vld  = 1'b0;
  endtask

  task automatic words(input int n, input int base);
    for (int i = 0; i < 4 * n; i++) pix(32'(base + i));
  endtask

  task automatic do_reset();
    wr_rst = 1'b1;
    idle(2);
    wr_rst = 1'b0;
    idle(2);
  endtask

  int wb, rb, u0;

  initial begin
    bus.vs_in    = 1'b0;
    bus.pix_vld  = 1'b0;
    bus.pix_data = '0;
    idle(3);
    chk("rst_wr_en",    bus.buf_wr_en, 0);
    chk("rst_wr_data",  bus.buf_wr_data, 0);
    chk("rst_req",      bus.burst_req, 0);
    chk("rst_ddr_addr", bus.burst_ddr_addr, 0);
    chk("rst_ovf",      bus.overflow, 0);
    wr_rst = 1'b0;
    idle(2);

    // 64 pixels, engine acks after 2 cycles and finishes 20 later.
    auto_eng = 1'b1;
    wb = wa_q.size(); rb = rb_q.size();
    for (int i = 0; i < 64; i++) pix(32'(i));
    idle(40);
    chk("t1_wr_cnt", wa_q.size() - wb, 16);
    for (int i = 0; i < 16; i++) chk($sformatf("t1_addr%0d", i), wa_q[wb + i], i);
    chk("t1_word0",  wd_q[wb],      {32'd3, 32'd2, 32'd1, 32'd0});
    chk("t1_word15", wd_q[wb + 15], {32'd63, 32'd62, 32'd61, 32'd60});
    chk("t1_req_cnt", rb_q.size() - rb, 1);
    chk("t1_req_buf", rb_q[rb], 0);
    chk("t1_req_ddr", rd_q[rb], 0);
    chk("t1_occ",     dut.occ_q, 0);
    chk("t1_req_low", bus.burst_req, 0);

    // 128 words with the engine silent: one request, held stable.
    auto_eng = 1'b0;
    do_reset();
    wb = wa_q.size(); rb = rb_q.size(); u0 = unstable;
    words(128, 1000);
    idle(5);
    chk("t2_wr_cnt",   wa_q.size() - wb, 128);
    chk("t2_req_cnt",  rb_q.size() - rb, 1);
    chk("t2_req_held", bus.burst_req, 1);
    chk("t2_stable",   unstable - u0, 0);
    chk("t2_req0_buf", rb_q[rb], 0);
    chk("t2_occ",      dut.occ_q, 128);
    man_ack = 1'b1; tick(); man_ack = 1'b0;
    idle(3);
    man_done = 1'b1; tick(); man_done = 1'b0;
    idle(3);
    chk("t2_req_cnt2", rb_q.size() - rb, 2);
    chk("t2_req1_buf", rb_q[rb + 1], 16);
    chk("t2_req1_ddr", rd_q[rb + 1], 16);
    chk("t2_occ2",     dut.occ_q, 112);

    // Fill the buffer completely, then one more word is dropped.
    do_reset();
    wb = wa_q.size();
    words(1024, 0);
    idle(2);
    chk("t3_wr_cnt",   wa_q.size() - wb, 1024);
    chk("t3_last",     wa_q[wb + 1023], 1023);
    chk("t3_ovf_pre",  bus.overflow, 0);
    chk("t3_occ_full", dut.occ_q, 1024);
    words(1, 7);
    idle(2);
    chk("t3_drop_cnt", wa_q.size() - wb, 1024);
    chk("t3_ovf",      bus.overflow, 1);
    bus.vs_in = 1'b1; tick(); bus.vs_in = 1'b0;
    chk("t3_ovf_clr",  bus.overflow, 0);
    chk("t3_req_pre",  bus.burst_req, 1);
    wr_rst = 1'b1;
    #1;
    chk("t3_async_rst", bus.burst_req, 0);
    idle(2);
    wr_rst = 1'b0;
    idle(2);

    // Full buffer, completing word coincides with burst_done.
    wb = wa_q.size();
    words(1024, 0);
    idle(2);
    man_ack = 1'b1; tick(); man_ack = 1'b0;
    idle(2);
    chk("t4_occ_pre", dut.occ_q, 1024);
    pix(32'hA0); pix(32'hA1); pix(32'hA2);
    bus.pix_vld = 1'b1; bus.pix_data = 32'hA3; man_done = 1'b1;
    tick();
    bus.pix_vld = 1'b0; man_done = 1'b0;
    idle(2);
    chk("t4_wr_cnt", wa_q.size() - wb, 1025);
    chk("t4_addr",   wa_q[wb + 1024], 0);
    chk("t4_data",   wd_q[wb + 1024], {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("t4_occ",    dut.occ_q, 1009);
    chk("t4_ovf",    bus.overflow, 0);

    // Frame restart in IDLE with 5 unrequested words and a partial word.
    do_reset();
    auto_eng = 1'b1;
    words(16, 0);
    idle(40);
    words(5, 100);
    pix(32'h11); pix(32'h22);
    chk("t5_occ_pre", dut.occ_q, 5);
    wb = wa_q.size(); rb = rb_q.size();
    bus.vs_in = 1'b1; bus.pix_vld = 1'b1; bus.pix_data = 32'hB0;
    tick();
    bus.vs_in = 1'b0; bus.pix_vld = 1'b0;
    chk("t5_occ_keep", dut.occ_q, 5);
    pix(32'hB1); pix(32'hB2); pix(32'hB3);
    idle(2);
    chk("t5_addr", wa_q[wb], 16);
    chk("t5_data", wd_q[wb], {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    words(15, 200);
    idle(5);
    chk("t5_req_buf", rb_q[rb], 16);
    chk("t5_req_ddr", rd_q[rb], 0);
    idle(40);

    // Two 32-word frames back to back: DDR address wraps at the frame end.
    do_reset();
    rb = rb_q.size();
    words(64, 0);
    idle(60);
    chk("t6_req_cnt", rb_q.size() - rb, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_buf%0d", i), rb_q[rb + i], 16 * i);
      chk($sformatf("t6_ddr%0d", i), rd_q[rb + i], 16 * (i % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
